// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-requester memory arbiter: FSM state, owner tag and
// the registered memory request bundle.
package mem_arbiter_pkg;

   localparam int ARB_ADDR_W = 64;
   localparam int ARB_DATA_W = 64;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_LS = 1'b1
   } owner_t;

   typedef struct packed {
      logic [ARB_ADDR_W-1:0]   addr;
      logic                    wen;
      logic [ARB_DATA_W-1:0]   wdata;
      logic [ARB_DATA_W/8-1:0] wmask;
   } mem_req_t;

endpackage

// File: rtl/mem_arbiter_streak_ctr.sv
// IDLE grant decision: LS wins unless IF has watched MAX_LS_STREAK LS grants
// in a row, in which case IF gets the next slot.
module arb_streak_ctr #(
   parameter int MAX_LS_STREAK = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic i_en,
   input  logic i_if_valid,
   input  logic i_ls_valid,
   output logic o_grant_ls,
   output logic o_grant_if
);

   localparam int               CNT_W   = $clog2(MAX_LS_STREAK + 1);
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_LS_STREAK);

   logic [CNT_W-1:0] r_streak;
   logic             w_at_max;

   assign w_at_max   = (r_streak == MAX_CNT);
   assign o_grant_ls = i_en & i_ls_valid & ~(i_if_valid & w_at_max);
   assign o_grant_if = i_en & i_if_valid & ~o_grant_ls;

   // Streak only counts LS wins that actually made IF wait.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_streak <= '0;
      end else if (o_grant_if || (o_grant_ls && !i_if_valid)) begin
         r_streak <= '0;
      end else if (o_grant_ls && !w_at_max) begin
         r_streak <= r_streak + CNT_W'(1);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store with one
// transaction outstanding; LS has priority, bounded by a streak limiter.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W        = 64,
   parameter int DATA_W        = 64,
   parameter int MAX_LS_STREAK = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req_valid,
   output logic                if_req_ready,
   input  logic [ADDR_W-1:0]   if_req_addr,
   input  logic                if_flush,
   output logic                if_resp_valid,
   output logic [DATA_W-1:0]   if_resp_data,
   input  logic                ls_req_valid,
   output logic                ls_req_ready,
   input  logic [ADDR_W-1:0]   ls_req_addr,
   input  logic                ls_req_wen,
   input  logic [DATA_W-1:0]   ls_req_wdata,
   input  logic [DATA_W/8-1:0] ls_req_wmask,
   output logic                ls_resp_valid,
   output logic [DATA_W-1:0]   ls_resp_data,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [ADDR_W-1:0]   mem_req_addr,
   output logic                mem_req_wen,
   output logic [DATA_W-1:0]   mem_req_wdata,
   output logic [DATA_W/8-1:0] mem_req_wmask,
   input  logic                mem_resp_valid,
   input  logic [DATA_W-1:0]   mem_resp_data,
   output logic                busy
);

   arb_state_t r_state;
   arb_state_t w_state_nxt;
   owner_t     r_owner;
   logic       r_drop;
   mem_req_t   r_req;

   logic w_idle;
   logic w_grant_ls;
   logic w_grant_if;
   logic w_resp_done;
   logic w_drop_now;

   assign w_idle      = (r_state == IDLE);
   assign w_resp_done = (r_state == WAIT) && mem_resp_valid;
   // A flush landing in the response cycle itself still suppresses it.
   assign w_drop_now  = r_drop || (if_flush && r_owner == OWN_IF);

   arb_streak_ctr #(
      .MAX_LS_STREAK (MAX_LS_STREAK)
   ) u_streak (
      .clk        (clk),
      .rst        (rst),
      .i_en       (w_idle),
      .i_if_valid (if_req_valid),
      .i_ls_valid (ls_req_valid),
      .o_grant_ls (w_grant_ls),
      .o_grant_if (w_grant_if)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_grant_ls || w_grant_if) w_state_nxt = ISSUE;
         ISSUE:   if (mem_req_ready)            w_state_nxt = WAIT;
         WAIT:    if (mem_resp_valid)           w_state_nxt = IDLE;
         default:                               w_state_nxt = IDLE;
      endcase
   end

   // Readies are gated by rst so nothing handshakes while reset is held.
   always_comb begin
      if_req_ready  = 1'b0;
      ls_req_ready  = 1'b0;
      mem_req_valid = 1'b0;
      if_resp_valid = 1'b0;
      ls_resp_valid = 1'b0;
      busy          = 1'b0;
      case (r_state)
         IDLE: begin
            if_req_ready = rst & w_grant_if;
            ls_req_ready = rst & w_grant_ls;
         end
         ISSUE: begin
            mem_req_valid = 1'b1;
            busy          = 1'b1;
         end
         WAIT: begin
            busy          = 1'b1;
            ls_resp_valid = mem_resp_valid && (r_owner == OWN_LS);
            if_resp_valid = mem_resp_valid && (r_owner == OWN_IF) && !w_drop_now;
         end
         default: ;
      endcase
   end

   assign if_resp_data  = if_resp_valid ? mem_resp_data : '0;
   assign ls_resp_data  = ls_resp_valid ? mem_resp_data : '0;
   assign mem_req_addr  = r_req.addr[ADDR_W-1:0];
   assign mem_req_wen   = r_req.wen;
   assign mem_req_wdata = r_req.wdata[DATA_W-1:0];
   assign mem_req_wmask = r_req.wmask[DATA_W/8-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_req   <= '0;
         r_owner <= OWN_IF;
         r_drop  <= 1'b0;
      end else begin
         if (w_grant_ls) begin
            r_req.addr  <= ARB_ADDR_W'(ls_req_addr);
            r_req.wen   <= ls_req_wen;
            r_req.wdata <= ARB_DATA_W'(ls_req_wdata);
            r_req.wmask <= (ARB_DATA_W/8)'(ls_req_wmask);
            r_owner     <= OWN_LS;
         end else if (w_grant_if) begin
            r_req.addr  <= ARB_ADDR_W'(if_req_addr);
            r_req.wen   <= 1'b0;
            r_req.wdata <= '0;
            r_req.wmask <= '0;
            r_owner     <= OWN_IF;
         end
         if (w_resp_done) begin
            r_drop <= 1'b0;
         end else if (if_flush && (w_grant_if || (!w_idle && r_owner == OWN_IF))) begin
            r_drop <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: memory side is driven by hand per scenario.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        if_req_valid, if_req_ready, if_flush, if_resp_valid;
   logic [63:0] if_req_addr, if_resp_data;
   logic        ls_req_valid, ls_req_ready, ls_req_wen, ls_resp_valid;
   logic [63:0] ls_req_addr, ls_req_wdata, ls_resp_data;
   logic [7:0]  ls_req_wmask;
   logic        mem_req_valid, mem_req_ready, mem_req_wen, mem_resp_valid, busy;
   logic [63:0] mem_req_addr, mem_req_wdata, mem_resp_data;
   logic [7:0]  mem_req_wmask;

   int checks = 0;
   int errors = 0;

   mem_arbiter #(.ADDR_W(64), .DATA_W(64), .MAX_LS_STREAK(4)) dut (
      .clk(clk), .rst(rst),
      .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
      .if_flush(if_flush), .if_resp_valid(if_resp_valid), .if_resp_data(if_resp_data),
      .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
      .ls_req_wen(ls_req_wen), .ls_req_wdata(ls_req_wdata), .ls_req_wmask(ls_req_wmask),
      .ls_resp_valid(ls_resp_valid), .ls_resp_data(ls_resp_data),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
      .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wmask(mem_req_wmask),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic test_reset;
      #1;
      checks++;
      if (busy !== 1'b0 || mem_req_valid !== 1'b0 || if_req_ready !== 1'b0 || ls_req_ready !== 1'b0 ||
          mem_req_addr !== 64'h0 || mem_req_wmask !== 8'h0 || mem_req_wen !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: busy=%b mreqv=%b rdy=%b%b addr=%h mask=%h wen=%b exp all 0",
                  busy, mem_req_valid, if_req_ready, ls_req_ready, mem_req_addr, mem_req_wmask, mem_req_wen);
      end
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (dut.r_state !== IDLE || dut.u_streak.r_streak !== 3'd0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: state=%0d streak=%0d busy=%b exp 0 0 0",
                  dut.r_state, dut.u_streak.r_streak, busy);
      end
   endtask

   task automatic test_single_if;
      if_req_valid = 1'b1; if_req_addr = 64'h8000_0000; #1;
      checks++;
      if (if_req_ready !== 1'b1 || ls_req_ready !== 1'b0) begin
         errors++; $display("FAIL single_if_ready: if=%b ls=%b exp 1 0", if_req_ready, ls_req_ready);
      end
      @(posedge clk); #1; if_req_valid = 1'b0; mem_req_ready = 1'b1; #1;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0000 || mem_req_wmask !== 8'h0 ||
          mem_req_wen !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_if_issue: v=%b addr=%h mask=%h wen=%b busy=%b exp 1 80000000 00 0 1",
                  mem_req_valid, mem_req_addr, mem_req_wmask, mem_req_wen, busy);
      end
      @(posedge clk); #1; mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h13; #1;
      checks++;
      if (if_resp_valid !== 1'b1 || if_resp_data !== 64'h13 || ls_resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_if_resp: v=%b data=%h lsv=%b exp 1 13 0", if_resp_valid, if_resp_data, ls_resp_valid);
      end
      @(posedge clk); #1; mem_resp_valid = 1'b0; mem_resp_data = '0; #1;
      checks++;
      if (busy !== 1'b0 || if_resp_valid !== 1'b0 || if_resp_data !== 64'h0) begin
         errors++; $display("FAIL single_if_done: busy=%b v=%b data=%h exp 0 0 0", busy, if_resp_valid, if_resp_data);
      end
   endtask

   task automatic test_streak;
      logic [9:0] exp_ls;
      int         exp_streak;
      exp_ls = 10'b0111101111;
      if_req_valid = 1'b1; if_req_addr = 64'h1000;
      ls_req_valid = 1'b1; ls_req_addr = 64'h2000; ls_req_wen = 1'b0;
      for (int k = 0; k < 10; k++) begin
         exp_streak = (k == 4 || k == 9) ? 0 : (k % 5) + 1;
         #1;
         checks++;
         if (ls_req_ready !== exp_ls[k] || if_req_ready !== !exp_ls[k]) begin
            errors++;
            $display("FAIL streak_grant[%0d]: ls=%b if=%b exp ls=%b", k, ls_req_ready, if_req_ready, exp_ls[k]);
         end
         @(posedge clk); #1; mem_req_ready = 1'b1; #1;
         checks++;
         if (mem_req_addr !== (exp_ls[k] ? 64'h2000 : 64'h1000) || if_req_ready !== 1'b0 ||
             ls_req_ready !== 1'b0 || dut.u_streak.r_streak !== 3'(exp_streak)) begin
            errors++;
            $display("FAIL streak_issue[%0d]: addr=%h rdy=%b%b streak=%0d exp streak %0d",
                     k, mem_req_addr, if_req_ready, ls_req_ready, dut.u_streak.r_streak, exp_streak);
         end
         @(posedge clk); #1; mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'(k + 100); #1;
         checks++;
         if (ls_resp_valid !== exp_ls[k] || if_resp_valid !== !exp_ls[k] ||
             (exp_ls[k] ? ls_resp_data : if_resp_data) !== 64'(k + 100)) begin
            errors++;
            $display("FAIL streak_resp[%0d]: lsv=%b ifv=%b lsd=%h ifd=%h exp data %h",
                     k, ls_resp_valid, if_resp_valid, ls_resp_data, if_resp_data, 64'(k + 100));
         end
         @(posedge clk); #1; mem_resp_valid = 1'b0;
      end
      if_req_valid = 1'b0; ls_req_valid = 1'b0;
   endtask

   task automatic test_store_stall;
      if_req_valid = 1'b1; if_req_addr = 64'h1000;
      ls_req_valid = 1'b1; ls_req_addr = 64'h8000_1000; ls_req_wen = 1'b1;
      ls_req_wdata = 64'hDEAD_BEEF; ls_req_wmask = 8'h0F; #1;
      checks++;
      if (ls_req_ready !== 1'b1 || if_req_ready !== 1'b0) begin
         errors++; $display("FAIL store_grant: ls=%b if=%b exp 1 0", ls_req_ready, if_req_ready);
      end
      @(posedge clk); #1; ls_req_valid = 1'b0; ls_req_wdata = '0; ls_req_wmask = '0; ls_req_wen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mem_req_ready = (i == 3); #1;
         checks++;
         if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_1000 || mem_req_wdata !== 64'hDEAD_BEEF ||
             mem_req_wmask !== 8'h0F || mem_req_wen !== 1'b1 || if_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL store_hold[%0d]: v=%b addr=%h wd=%h mask=%h wen=%b ifrdy=%b", i,
                     mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wmask, mem_req_wen, if_req_ready);
         end
         @(posedge clk); #1;
      end
      mem_req_ready = 1'b0; #1;
      checks++;
      if (ls_resp_valid !== 1'b0 || ls_resp_data !== 64'h0 || if_req_ready !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL store_wait: lsv=%b lsd=%h ifrdy=%b busy=%b exp 0 0 0 1",
                            ls_resp_valid, ls_resp_data, if_req_ready, busy);
      end
      @(posedge clk); #1; mem_resp_valid = 1'b1; mem_resp_data = 64'h0; #1;
      checks++;
      if (ls_resp_valid !== 1'b1 || if_resp_valid !== 1'b0 || if_req_ready !== 1'b0) begin
         errors++; $display("FAIL store_ack: lsv=%b ifv=%b ifrdy=%b exp 1 0 0", ls_resp_valid, if_resp_valid, if_req_ready);
      end
      @(posedge clk); #1; mem_resp_valid = 1'b0; #1;
      checks++;
      if (ls_resp_valid !== 1'b0 || if_req_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL store_after: lsv=%b ifrdy=%b busy=%b exp 0 1 0", ls_resp_valid, if_req_ready, busy);
      end
      if_req_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_flush;
      if_req_valid = 1'b1; if_req_addr = 64'h3000; #1;
      @(posedge clk); #1; if_req_valid = 1'b0; mem_req_ready = 1'b1;
      @(posedge clk); #1; mem_req_ready = 1'b0; if_flush = 1'b1;
      @(posedge clk); #1; if_flush = 1'b0;
      @(posedge clk); #1; mem_resp_valid = 1'b1; mem_resp_data = 64'h55; #1;
      checks++;
      if (if_resp_valid !== 1'b0 || if_resp_data !== 64'h0 || busy !== 1'b1) begin
         errors++; $display("FAIL flush_drop: v=%b data=%h busy=%b exp 0 0 1", if_resp_valid, if_resp_data, busy);
      end
      @(posedge clk); #1; mem_resp_valid = 1'b0;
      if_req_valid = 1'b1; if_req_addr = 64'h3008; #1;
      checks++;
      if (if_req_ready !== 1'b1 || busy !== 1'b0) begin
         errors++; $display("FAIL flush_recover: ifrdy=%b busy=%b exp 1 0", if_req_ready, busy);
      end
      @(posedge clk); #1; if_req_valid = 1'b0; mem_req_ready = 1'b1;
      @(posedge clk); #1; mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h66; #1;
      checks++;
      if (if_resp_valid !== 1'b1 || if_resp_data !== 64'h66) begin
         errors++; $display("FAIL flush_next_resp: v=%b data=%h exp 1 66", if_resp_valid, if_resp_data);
      end
      // Flush raised in the IF handshake cycle, then a flush during an LS load.
      @(posedge clk); #1; mem_resp_valid = 1'b0; if_req_valid = 1'b1; if_flush = 1'b1;
      @(posedge clk); #1; if_req_valid = 1'b0; if_flush = 1'b0; mem_req_ready = 1'b1;
      @(posedge clk); #1; mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h77; #1;
      checks++;
      if (if_resp_valid !== 1'b0) begin
         errors++; $display("FAIL flush_at_hs: v=%b exp 0", if_resp_valid);
      end
      @(posedge clk); #1; mem_resp_valid = 1'b0; ls_req_valid = 1'b1; ls_req_addr = 64'h5000;
      @(posedge clk); #1; ls_req_valid = 1'b0; mem_req_ready = 1'b1; if_flush = 1'b1;
      @(posedge clk); #1; mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h88; #1;
      checks++;
      if (ls_resp_valid !== 1'b1 || ls_resp_data !== 64'h88 || if_resp_valid !== 1'b0) begin
         errors++; $display("FAIL flush_ls_unaffected: lsv=%b lsd=%h ifv=%b exp 1 88 0",
                            ls_resp_valid, ls_resp_data, if_resp_valid);
      end
      @(posedge clk); #1; mem_resp_valid = 1'b0; if_flush = 1'b0;
   endtask

   task automatic test_async_reset;
      if_req_valid = 1'b1; ls_req_valid = 1'b1; ls_req_addr = 64'h4000; ls_req_wen = 1'b0;
      @(posedge clk); #1; if_req_valid = 1'b0; mem_req_ready = 1'b1; #1;
      checks++;
      if (dut.u_streak.r_streak !== 3'd1 || mem_req_addr !== 64'h4000) begin
         errors++; $display("FAIL pre_reset: streak=%0d addr=%h exp 1 4000", dut.u_streak.r_streak, mem_req_addr);
      end
      @(posedge clk); #1; mem_req_ready = 1'b0;
      #3; rst = 1'b0; #1;
      checks++;
      if (busy !== 1'b0 || mem_req_valid !== 1'b0 || mem_req_addr !== 64'h0 || mem_req_wdata !== 64'h0 ||
          mem_req_wmask !== 8'h0 || mem_req_wen !== 1'b0 || ls_req_ready !== 1'b0 || if_req_ready !== 1'b0 ||
          ls_resp_valid !== 1'b0 || if_resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_outputs: busy=%b v=%b addr=%h rdy=%b%b exp all 0",
                  busy, mem_req_valid, mem_req_addr, if_req_ready, ls_req_ready);
      end
      repeat (2) @(posedge clk);
      #4; rst = 1'b1; #1;
      checks++;
      if (dut.r_state !== IDLE || dut.u_streak.r_streak !== 3'd0 || ls_req_ready !== 1'b1) begin
         errors++; $display("FAIL post_reset: state=%0d streak=%0d lsrdy=%b exp 0 0 1",
                            dut.r_state, dut.u_streak.r_streak, ls_req_ready);
      end
      @(posedge clk); #1; ls_req_valid = 1'b0; mem_req_ready = 1'b1; #1;
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h4000) begin
         errors++; $display("FAIL post_reset_issue: v=%b addr=%h exp 1 4000", mem_req_valid, mem_req_addr);
      end
      @(posedge clk); #1; mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 64'h99; #1;
      checks++;
      if (ls_resp_valid !== 1'b1 || ls_resp_data !== 64'h99) begin
         errors++; $display("FAIL post_reset_resp: v=%b data=%h exp 1 99", ls_resp_valid, ls_resp_data);
      end
      @(posedge clk); #1; mem_resp_valid = 1'b0;
   endtask

   task automatic test_spurious_resp;
      mem_resp_valid = 1'b1; mem_resp_data = 64'hBAD; #1;
      checks++;
      if (if_resp_valid !== 1'b0 || ls_resp_valid !== 1'b0 || if_resp_data !== 64'h0 || ls_resp_data !== 64'h0) begin
         errors++; $display("FAIL spurious_resp: ifv=%b lsv=%b ifd=%h lsd=%h exp all 0",
                            if_resp_valid, ls_resp_valid, if_resp_data, ls_resp_data);
      end
      @(posedge clk); #1; mem_resp_valid = 1'b0; #1;
      checks++;
      if (dut.r_state !== IDLE || busy !== 1'b0) begin
         errors++; $display("FAIL spurious_state: state=%0d busy=%b exp 0 0", dut.r_state, busy);
      end
   endtask

   initial begin
      rst = 1'b0;
      if_req_valid = 1'b0; if_req_addr = '0; if_flush = 1'b0;
      ls_req_valid = 1'b0; ls_req_addr = '0; ls_req_wen = 1'b0; ls_req_wdata = '0; ls_req_wmask = '0;
      mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
      test_reset();
      test_single_if();
      test_streak();
      test_store_stall();
      test_flush();
      test_async_reset();
      test_spurious_resp();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one memory port between two requesters: the instruction-fetch requester (IF) and the load/store requester (LS).
- Sits between the pipeline's fetch and memory stages and a single unified memory/bus slave. Replaces the separate rom/ram combinational accesses.
- One outstanding transaction at a time.
- LS has priority. A streak limiter keeps IF from starving. A fetch flush discards the response to a stale fetch.

Parameters:
ADDR_W, 64, address width (matches ImmWidth)
DATA_W, 64, data width (matches RegWidth)
MAX_LS_STREAK, 4, consecutive LS grants allowed while IF waits; minimum 1

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
if_req_valid  input  1  fetch request
if_req_ready  output  1  fetch request accepted this cycle
if_req_addr  input  ADDR_W  fetch address
if_flush  input  1  discard any in-flight fetch response
if_resp_valid  output  1  fetch data valid (1-cycle pulse)
if_resp_data  output  DATA_W  fetch data
ls_req_valid  input  1  load/store request
ls_req_ready  output  1  LS request accepted this cycle
ls_req_addr  input  ADDR_W  LS address
ls_req_wen  input  1  1 = store
ls_req_wdata  input  DATA_W  store data
ls_req_wmask  input  DATA_W/8  byte write mask
ls_resp_valid  output  1  LS response (load data or store ack), 1-cycle pulse
ls_resp_data  output  DATA_W  load data
mem_req_valid  output  1  request to memory
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  ADDR_W  registered address
mem_req_wen  output  1  registered write enable
mem_req_wdata  output  DATA_W  registered write data
mem_req_wmask  output  DATA_W/8  registered mask (all zero for IF)
mem_resp_valid  input  1  memory response, exactly one per accepted request
mem_resp_data  input  DATA_W  memory read data
busy  output  1  FSM not in IDLE

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; streak counter, owner and drop flag clear.
  - All mem_req_* registers go to 0; all valid/ready outputs are 0.
  - A transaction in flight is abandoned; the memory must be reset by the same rst.
- FSM states IDLE, ISSUE, WAIT.
- IDLE:
  - Grant is combinational.
  - grant_ls = ls_req_valid & !(if_req_valid & streak==MAX_LS_STREAK).
  - grant_if = if_req_valid & !grant_ls.
  - The matching *_req_ready equals its grant; the other ready is 0.
  - On handshake: latch addr/wen/wdata/wmask into the mem_req_* registers. IF forces wen=0 and wmask=0. Record owner, go to ISSUE.
- Streak counter:
  - On an LS grant while if_req_valid=1: streak += 1, saturating at MAX_LS_STREAK.
  - On an IF grant, or an LS grant with if_req_valid=0: streak = 0.
- ISSUE:
  - mem_req_valid=1 with the fields held stable.
  - On mem_req_ready=1, go to WAIT.
  - Both requester readies are 0.
- WAIT:
  - On mem_resp_valid=1, go to IDLE.
  - If owner=LS: ls_resp_valid=1 and ls_resp_data=mem_resp_data, same cycle (combinational pass-through).
  - If owner=IF and drop=0: if_resp_valid=1 and if_resp_data=mem_resp_data.
  - If drop=1: no response is raised and drop clears.
- Flush:
  - if_flush=1 while owner=IF and state is ISSUE or WAIT sets drop=1.
  - The memory transaction still completes; the arbiter is never stuck.
  - if_flush in the same cycle as the IF handshake in IDLE also sets drop.
  - if_flush in the response cycle itself suppresses that response.
  - if_flush has no effect on LS transactions.
- Latency: handshake at cycle N → mem_req_valid at N+1. With mem_req_ready=1 and a 1-cycle memory, the response arrives at N+2 and IDLE is re-entered at N+3. Back-to-back throughput is 1 transaction per 3 cycles minimum.
- mem_resp_valid outside WAIT is ignored.
- busy=1 in ISSUE and WAIT.
- Resp data outputs are 0 whenever the corresponding valid is 0.

Decomposition:
- Shared package holds:
  - The arb_state_t enum (IDLE/ISSUE/WAIT).
  - The owner_t enum (OWN_IF/OWN_LS).
  - A mem_req_t struct {addr, wen, wdata, wmask}.
- Sub-module arb_streak_ctr: the saturating counter plus the grant_ls/grant_if logic. It is purely the IDLE grant decision and is independently testable.

Test Plan:
- Single IF request, addr 0x80000000; memory ready=1, 1-cycle response 0x00000013 → if_req_ready at cycle 0; mem_req_valid with addr 0x80000000 and wmask 0 at cycle 1; if_resp_valid with data 0x13 at cycle 2; busy low at cycle 3.
- IF and LS both valid continuously, MAX_LS_STREAK=4 → grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF; streak returns to 0 after each IF grant.
- LS store addr 0x80001000, wdata 0xDEADBEEF, wmask 0x0F; mem_req_ready held 0 for 3 cycles → request fields stable throughout; ls_resp_valid one pulse after mem_resp_valid; no IF grant until IDLE.
- IF request issued, if_flush pulsed during WAIT, memory responds 2 cycles later → if_resp_valid stays 0; next IF request is accepted normally and its response is delivered.
- rst driven low mid-WAIT, asynchronously and between clock edges → all outputs 0 immediately; after release, state IDLE and streak 0; a fresh LS request completes normally.
- mem_resp_valid pulsed spuriously while in IDLE → no resp_valid on either side; state unchanged.
